// File: rtl/io_step_harness_pkg.sv
// io_step_harness_pkg: opcodes, response bytes, FSM states and byte math
// shared by the step harness and its byte serializer.
package io_step_harness_pkg;

    typedef enum logic [7:0] {
        OP_SET_IN   = 8'h01,
        OP_READ_OUT = 8'h02,
        OP_STEP     = 8'h03,
        OP_RST_ON   = 8'h04,
        OP_RST_OFF  = 8'h05,
        OP_TRACE    = 8'h06,
        OP_RUN      = 8'h07,
        OP_HALT     = 8'h08
    } opcode_e;

    localparam logic [7:0] ACK_BYTE = 8'hAA;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ARGS,
        ST_STEP_HI,
        ST_STEP_LO,
        ST_RUN_IDLE,
        ST_SEND,
        ST_TRACE_SEND
    } state_e;

    typedef enum logic [1:0] {
        RSP_ACK,
        RSP_ERR,
        RSP_READ,
        RSP_TRACE
    } resp_e;

    function automatic int nbytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/io_step_harness_tx_ser.sv
// io_step_tx_ser: loads a wide word and a byte count, then emits the
// bytes LSB-first, holding each byte until the PHY takes it.
module io_step_tx_ser
    import io_step_harness_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [W-1:0]  word,
    input  logic [CW-1:0] count,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy
);

    logic [W-1:0]  shreg;
    logic [CW-1:0] left;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            shreg    <= '0;
            left     <= '0;
        end else if (load) begin
            tx_data  <= word[7:0];
            shreg    <= word >> 8;
            left     <= count - 1'b1;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            if (left == '0) begin
                tx_valid <= 1'b0;
            end else begin
                tx_data <= shreg[7:0];
                shreg   <= shreg >> 8;
                left    <= left - 1'b1;
            end
        end
    end

    assign busy = tx_valid;

endmodule

// File: rtl/io_step_harness.sv
// io_step_harness: byte-command debug core driving a chip's inputs, clock
// and reset. Define HARNESS_TRACE_EN for the TRACE opcode and sample buffer.
module io_step_harness
    import io_step_harness_pkg::*;
#(
    parameter int IO_IN_W     = 12,
    parameter int IO_OUT_W    = 12,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [IO_IN_W-1:0]  chip_inputs,
    input  logic [IO_OUT_W-1:0] chip_outputs,
    output logic                chip_clock,
    output logic                chip_reset
);

    localparam int NB_IN  = nbytes(IO_IN_W);
    localparam int NB_OUT = nbytes(IO_OUT_W);
    localparam int AW     = 8 * NB_IN;
    localparam int OB     = 8 * NB_OUT;
    localparam int CW     = $clog2(3 + TRACE_DEPTH * NB_OUT);
`ifdef HARNESS_TRACE_EN
    localparam int SW  = 8 * (2 + TRACE_DEPTH * NB_OUT);
    localparam int TIW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int TCW = $clog2(TRACE_DEPTH + 1);
`else
    localparam int SW = OB;
`endif

    state_e        state;
    resp_e         sel;
    resp_e         dec_rsp;
    logic          running;
    logic          load_pend;
    logic          dec_args;
    logic          is_step;
    logic          is_ack;
    logic          rx_fire;
    logic          ser_load;
    logic          ser_busy;
    logic [7:0]    cur_op;
    logic [7:0]    arg_idx;
    logic [8:0]    step_cnt;
    logic [AW-1:0] argbuf;
    logic [AW-1:0] nbuf;
    logic [SW-1:0] ser_word;
    logic [CW-1:0] ser_cnt;
`ifdef HARNESS_TRACE_EN
    logic [IO_OUT_W-1:0] tr_buf [TRACE_DEPTH];
    logic [TCW-1:0]      tr_cnt;
`endif

    assign rx_fire  = rx_valid && rx_ready;
    assign ser_load = load_pend &&
                      (state == ST_SEND || state == ST_TRACE_SEND);

    always_comb begin
        nbuf     = AW'({rx_data, argbuf} >> 8);
        is_step  = rx_data == OP_STEP;
`ifdef HARNESS_TRACE_EN
        is_step  = is_step || rx_data == OP_TRACE;
`endif
        is_ack   = rx_data inside {OP_RST_ON, OP_RST_OFF, OP_RUN, OP_HALT};
        dec_args = 1'b0;
        dec_rsp  = RSP_ACK;
        unique case (1'b1)
            rx_data == OP_SET_IN:   dec_args = 1'b1;
            rx_data == OP_READ_OUT: dec_rsp = RSP_READ;
            is_step: begin
                dec_args = !running;
                if (running) dec_rsp = RSP_ERR;
            end
            is_ack:  dec_rsp = RSP_ACK;
            default: dec_rsp = RSP_ERR;
        endcase
    end

    always_comb begin
        ser_word = '0;
        ser_cnt  = CW'(1);
        unique case (sel)
            RSP_ACK: ser_word[7:0] = ACK_BYTE;
            RSP_ERR: ser_word[7:0] = ERR_BYTE;
            RSP_READ: begin
                ser_word[IO_OUT_W-1:0] = chip_outputs;
                ser_cnt = CW'(NB_OUT);
            end
            default: begin
`ifdef HARNESS_TRACE_EN
                // count byte, samples in capture order, then ACK
                ser_word[7:0] = 8'(tr_cnt);
                for (int i = 0; i < TRACE_DEPTH; i++)
                    if (i < int'(tr_cnt))
                        ser_word[8 + i * OB +: IO_OUT_W] = tr_buf[i];
                ser_word[8 + int'(tr_cnt) * OB +: 8] = ACK_BYTE;
                ser_cnt = CW'(2 + int'(tr_cnt) * NB_OUT);
`else
                ser_word[7:0] = ERR_BYTE;
`endif
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            sel         <= RSP_ACK;
            rx_ready    <= 1'b0;
            chip_inputs <= '0;
            chip_clock  <= 1'b0;
            chip_reset  <= 1'b1;
            running     <= 1'b0;
            load_pend   <= 1'b0;
            cur_op      <= 8'h00;
            arg_idx     <= 8'h00;
            step_cnt    <= 9'd0;
            argbuf      <= '0;
`ifdef HARNESS_TRACE_EN
            tr_cnt      <= '0;
`endif
        end else begin
            if (running) chip_clock <= ~chip_clock;
            unique case (state)
                ST_IDLE, ST_RUN_IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        cur_op  <= rx_data;
                        arg_idx <= 8'h00;
                        if (rx_data == OP_RST_ON)  chip_reset <= 1'b1;
                        if (rx_data == OP_RST_OFF) chip_reset <= 1'b0;
                        if (rx_data == OP_RUN)     running <= 1'b1;
                        // halting lets a high phase finish by forcing low
                        if (rx_data == OP_HALT) begin
                            running    <= 1'b0;
                            chip_clock <= 1'b0;
                        end
                        if (dec_args) begin
                            state <= ST_GET_ARGS;
                        end else begin
                            state     <= ST_SEND;
                            rx_ready  <= 1'b0;
                            load_pend <= 1'b1;
                            sel       <= dec_rsp;
                        end
                    end
                end
                ST_GET_ARGS: begin
                    if (rx_fire && cur_op == OP_SET_IN) begin
                        argbuf  <= nbuf;
                        arg_idx <= arg_idx + 1'b1;
                        if (arg_idx == 8'(NB_IN - 1)) begin
                            chip_inputs <= nbuf[IO_IN_W-1:0];
                            state       <= ST_SEND;
                            rx_ready    <= 1'b0;
                            load_pend   <= 1'b1;
                            sel         <= RSP_ACK;
                        end
                    end else if (rx_fire) begin
                        step_cnt   <= (rx_data == 8'h00) ?
                                      9'd256 : {1'b0, rx_data};
                        chip_clock <= 1'b1;
                        state      <= ST_STEP_HI;
                        rx_ready   <= 1'b0;
`ifdef HARNESS_TRACE_EN
                        tr_cnt     <= '0;
`endif
                    end
                end
                ST_STEP_HI: begin
                    chip_clock <= 1'b0;
                    step_cnt   <= step_cnt - 1'b1;
                    state      <= ST_STEP_LO;
                end
                ST_STEP_LO: begin
`ifdef HARNESS_TRACE_EN
                    if (cur_op == OP_TRACE &&
                        int'(tr_cnt) < TRACE_DEPTH) begin
                        tr_buf[tr_cnt[TIW-1:0]] <= chip_outputs;
                        tr_cnt <= tr_cnt + 1'b1;
                    end
`endif
                    if (step_cnt == 9'd0) begin
                        load_pend <= 1'b1;
                        if (cur_op == OP_TRACE) begin
                            state <= ST_TRACE_SEND;
                            sel   <= RSP_TRACE;
                        end else begin
                            state <= ST_SEND;
                            sel   <= RSP_ACK;
                        end
                    end else begin
                        chip_clock <= 1'b1;
                        state      <= ST_STEP_HI;
                    end
                end
                ST_SEND, ST_TRACE_SEND: begin
                    if (load_pend) begin
                        load_pend <= 1'b0;
                    end else if (!ser_busy) begin
                        state    <= running ? ST_RUN_IDLE : ST_IDLE;
                        rx_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    io_step_tx_ser #(
        .W  (SW),
        .CW (CW)
    ) u_ser (
        .clock    (clock),
        .reset    (reset),
        .load     (ser_load),
        .word     (ser_word),
        .count    (ser_cnt),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (ser_busy)
    );

endmodule

// File: doc/io_step_harness.md
Name: io_step_harness

Overview:
- Parametrised, byte-stream-driven debug core that owns a chip-under-test's inputs, clock and reset. It is the successor to the fixed 12-bit harness.
- Sits between a UART byte PHY (valid/ready byte ports) and the design's io_in/io_out/clock/reset.
- Adds arbitrary IO widths, counted single-stepping, free-run/halt and error reporting.

Parameters:
- IO_IN_W, 12, width of chip_inputs
- IO_OUT_W, 12, width of chip_outputs
- TRACE_DEPTH, 16, trace buffer entries; used only with HARNESS_TRACE_EN

Ports:
- clock  in  1  harness clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  command byte from PHY
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  harness accepts rx_data this cycle
- tx_data  out  8  response byte to PHY
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  PHY accepts tx_data
- chip_inputs  out  IO_IN_W  driven onto chip io_in
- chip_outputs  in  IO_OUT_W  chip io_out
- chip_clock  out  1  generated chip clock
- chip_reset  out  1  chip reset, active-high

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high. Every output is registered.
- Reset values: chip_inputs=0, chip_clock=0, chip_reset=1, tx_valid=0, tx_data=0, rx_ready=0, FSM in IDLE, step counter=0.
- A reset mid-command aborts the command, discards partial arguments and drops any pending tx byte.
- Widths: NB_IN=ceil(IO_IN_W/8), NB_OUT=ceil(IO_OUT_W/8). Multi-byte words are little-endian. Unused high bits of the last byte are ignored on write and read as 0.
- Byte handshake: a byte transfers when valid&&ready in the same cycle.
  - rx_ready=1 only in IDLE, RUN_IDLE and GET_ARGS.
  - tx_data/tx_valid are held stable until tx_ready.
- Opcodes (response byte ACK=0xAA, ERR=0xEE):
  - 0x01 SET_IN + NB_IN bytes: chip_inputs updates in the cycle after the last argument byte; responds ACK.
  - 0x02 READ_OUT: samples chip_outputs in the cycle after the opcode is accepted; sends NB_OUT bytes.
  - 0x03 STEP + n: issues n chip_clock pulses (n=0 means 256), then ACK.
    - Each pulse is 1 cycle high followed by 1 cycle low, so 2n cycles total.
    - chip_clock rises the cycle after n is accepted.
  - 0x04 RST_ON / 0x05 RST_OFF: set or clear chip_reset the cycle after the opcode; ACK.
  - 0x07 RUN: ACK, then chip_clock toggles every cycle until HALT.
  - 0x08 HALT: completes the current high phase so chip_clock ends low; ACK.
  - Any other opcode: ERR; FSM returns to IDLE (or RUN_IDLE if running).
- FSM states: IDLE, GET_ARGS, STEP_HI, STEP_LO, RUN_IDLE, SEND, (TRACE_SEND).
  - IDLE → GET_ARGS when the opcode needs arguments; → SEND for no-argument opcodes.
  - GET_ARGS → STEP_HI or SEND.
  - STEP_HI ↔ STEP_LO until the counter reaches 0, then → SEND.
  - SEND → IDLE or RUN_IDLE after the last byte is accepted.
- While running:
  - SET_IN, READ_OUT, RST_ON/OFF and HALT are legal.
  - STEP and TRACE respond ERR.
  - RUN while already running responds ACK and is a no-op.
- HALT while stopped responds ACK and is a no-op.
- No command bytes are accepted while stepping or sending.

Optional Feature:
- Macro: HARNESS_TRACE_EN.
- Defined: opcode 0x06 TRACE + n behaves as STEP n. In addition, chip_outputs is sampled in each STEP_LO cycle into a TRACE_DEPTH buffer.
  - Only the first min(n,TRACE_DEPTH) samples are kept.
  - Response: a count byte, then each sample as NB_OUT bytes in capture order, then ACK.
- Undefined: 0x06 is an unknown opcode and responds ERR; no buffer is instantiated.

Decomposition:
- io_step_harness_pkg: opcode enum, ACK/ERR constants, FSM state enum, and a byte-count function ceil(w/8).
- Sub-module io_step_tx_ser: loads a wide word plus a byte count and emits bytes LSB-first over tx_valid/tx_ready. It is reused for READ_OUT, ACK/ERR and trace drain.

Test Plan (IO_IN_W=12, IO_OUT_W=12):
- Reset, then send 0x01,0x34,0xF2 → chip_inputs=0x234; tx sends 0xAA; chip_reset stays 1.
- chip_outputs=0xABC, send 0x02 → tx sends 0xBC then 0x0A; hold tx_ready low 5 cycles and check the byte stays stable.
- Send 0x05 then 0x03,0x03 → chip_reset=0; exactly 3 chip_clock rising edges over 6 cycles; then ACK; chip_clock ends 0.
- Send 0x07; after 10 cycles send 0x03 → ERR; then send 0x08 → ACK; chip_clock is 0 afterwards.
- Send 0x09 → ERR. Assert reset mid-STEP with n=0 (256 pulses) → outputs return to reset values next cycle; no ACK is emitted.
- HARNESS_TRACE_EN: chip increments io_out per clock; send 0x06,0x14 → 20 pulses; count byte 0x10; 16 samples in order; then ACK.
